// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry sequencer.
//   calc_state_t : entry FSM states (encoding is visible on the state LEDs)
//   calc_op_t    : ALU opcodes taken from the low switch bits
//   FLAG_*       : bit positions inside the 4-bit {N,Z,C,V} flag word
package calc_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } calc_state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_OR  = 2'd2,
    OP_AND = 2'd3
  } calc_op_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU for the calculator: ADD, SUB, OR, AND with {N,Z,C,V} flags.
//   a, b   : operands (WIDTH bits)
//   op     : calc_op_t opcode
//   result : truncated WIDTH-bit result
//   flags  : {N,Z,C,V}; C/V meaningful only for ADD/SUB, zero for logic ops
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  calc_op_t          op,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_sum;
  logic           carry;
  logic           ovf;

  // Subtraction as A + ~B + 1 so the carry out reads as "no borrow".
  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      OP_ADD: begin
        result = add_sum[WIDTH-1:0];
        carry  = add_sum[WIDTH];
        ovf    = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = sub_sum[WIDTH-1:0];
        carry  = sub_sum[WIDTH];
        ovf    = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);
      end
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[MSB];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator entry sequencer: captures operand A, operand B, then the opcode
// from the switch word on successive enter strobes, and holds the registered
// ALU result and flags for display.
//   clk, rst     : clock, asynchronous active-low reset
//   sw_data      : switch word (synchronous to clk)
//   enter_pulse  : one-cycle enter strobe
//   undo_pulse   : one-cycle undo strobe (only used with CALC_UNDO_EN)
//   state_o      : current state encoding for LEDs
//   op_a, op_b   : captured operands
//   opcode       : captured opcode
//   result/flags : registered ALU result and {N,Z,C,V}
//   result_valid : high only in SHOW
//   disp_value   : result in SHOW, otherwise live sw_data
// Build option: define CALC_UNDO_EN to let undo_pulse step back one state
// (undo wins over a simultaneous enter).
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  sw_data,
  input  logic              enter_pulse,
  input  logic              undo_pulse,
  output logic [1:0]        state_o,
  output logic [WIDTH-1:0]  op_a,
  output logic [WIDTH-1:0]  op_b,
  output logic [OPW-1:0]    opcode,
  output logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags,
  output logic              result_valid,
  output logic [WIDTH-1:0]  disp_value
);

  calc_state_t       state_q;
  calc_state_t       state_d;
  logic              undo_ev;
  logic              enter_ev;
  logic              load_a;
  logic              load_b;
  logic              load_op;
  logic [WIDTH-1:0]  alu_result;
  logic [FLAG_W-1:0] alu_flags;

`ifdef CALC_UNDO_EN
  assign undo_ev = undo_pulse;
`else
  logic unused_undo;
  assign unused_undo = undo_pulse;
  assign undo_ev     = 1'b0;
`endif

  // Undo has priority; a coincident enter is dropped.
  assign enter_ev = enter_pulse & ~undo_ev;

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (calc_op_t'(sw_data[1:0])),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT_A;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (undo_ev) begin
      unique case (state_q)
        WAIT_B:  state_d = WAIT_A;
        WAIT_OP: state_d = WAIT_B;
        SHOW:    state_d = WAIT_OP;
        default: state_d = state_q;
      endcase
    end else if (enter_ev) begin
      unique case (state_q)
        WAIT_A:  state_d = WAIT_B;
        WAIT_B:  state_d = WAIT_OP;
        WAIT_OP: state_d = SHOW;
        SHOW:    state_d = WAIT_A;
        default: state_d = WAIT_A;
      endcase
    end
  end

  // Output / load-enable decode
  always_comb begin
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    disp_value = sw_data;
    if (enter_ev) begin
      load_a  = (state_q == WAIT_A);
      load_b  = (state_q == WAIT_B);
      load_op = (state_q == WAIT_OP);
    end
    if (result_valid) disp_value = result;
  end

  // Datapath registers; result/flags load on the same edge as the opcode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a         <= '0;
      op_b         <= '0;
      opcode       <= '0;
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
    end else begin
      if (load_a) op_a <= sw_data;
      if (load_b) op_b <= sw_data;
      if (load_op) begin
        opcode <= sw_data[OPW-1:0];
        result <= alu_result;
        flags  <= alu_flags;
      end
      result_valid <= (state_d == SHOW);
    end
  end

  assign state_o = state_q;

endmodule
